// File: rtl/keyboard_io_port.sv
// PS/2 keyboard input port on the OTTER IOBUS: filters the PS/2 clock, receives
// 11-bit frames, buffers scan-code bytes in a small FIFO and raises a level interrupt.
module keyboard_io_port #(
  parameter logic [31:0] BASE_AD     = 32'h11000100,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INTR
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] CTRL_AD = BASE_AD + 32'd4;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

  // Synchronizer and filter state
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          clk_s, data_s, fall;

  // Receiver state
  rx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          push_q, push_d;
  logic [7:0]    push_byte_q, push_byte_d;
  logic          perr_set;

  // FIFO and register state
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ie_q, ie_d, perr_q, perr_d, ovf_q, ovf_d, intr_q, intr_d;
  logic          pop, full, push_ok, ovf_set, ctrl_wr;
  logic [31:0]   count_ext;
  logic [2:0]    cnt3;
  logic          unused_bits;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Two-flop synchronizers; idle PS/2 lines are high so reset to 1
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
      data_sync_q <= {data_sync_q[0], PS2_DATA};
    end
  end

  // Glitch filter: flip the filtered level after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    fall      = 1'b0;
    if (clk_s != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
        fall   = ~clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
  end

  // Receiver next-state: start, 8 data bits LSB first, odd parity, stop; plus timeout
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    par_d       = par_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    perr_set    = 1'b0;
    to_cnt_d    = (state_q == StIdle || fall) ? '0 : to_cnt_q + TW'(1);
    unique case (state_q)
      StIdle: begin
        if (fall && !data_s) begin
          state_d  = StData;
          bitcnt_d = '0;
          shift_d  = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d  = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = data_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          if (data_s && (^{shift_q, par_q})) begin
            push_d      = 1'b1;
            push_byte_d = shift_q;
          end else begin
            perr_set = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abandon a stalled partial frame silently
    if (state_q != StIdle && !fall && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d  = StIdle;
      to_cnt_d = '0;
    end
  end

  // FIFO, flag and interrupt next-state
  always_comb begin
    ctrl_wr  = IOBUS_WR && (IOBUS_ADDR == CTRL_AD);
    pop      = IOBUS_WR && (IOBUS_ADDR == BASE_AD) && (count_q != '0);
    full     = (count_q == CW'(DEPTH));
    push_ok  = push_q && (!full || pop);
    ovf_set  = push_q && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_byte_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ie_d   = ctrl_wr ? IOBUS_OUT[0] : ie_q;
    // Set takes priority over a same-cycle clear
    perr_d = perr_set | (perr_q & ~(ctrl_wr & IOBUS_OUT[1]));
    ovf_d  = ovf_set | (ovf_q & ~(ctrl_wr & IOBUS_OUT[2]));
    intr_d = ie_d & (count_d != '0);
  end

  // All sequential state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_q      <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= StIdle;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ie_q        <= 1'b0;
      perr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      filt_q      <= filt_d;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ie_q        <= ie_d;
      perr_q      <= perr_d;
      ovf_q       <= ovf_d;
      intr_q      <= intr_d;
    end
  end

  assign count_ext   = 32'(count_q);
  assign cnt3        = count_ext[2:0];
  assign unused_bits = ^{IOBUS_OUT[31:3], count_ext[31:3]};

  // Read mux; empty FIFO reads as all zeros
  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == BASE_AD) begin
      if (count_q != '0) IOBUS_IN = {23'b0, 1'b1, mem_q[rd_ptr_q]};
    end else if (IOBUS_ADDR == CTRL_AD) begin
      IOBUS_IN = {21'b0, cnt3, 5'b0, ovf_q, perr_q, ie_q};
    end
  end

  assign INTR = intr_q;

endmodule
